// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, opcodes and the
// decoded control bundle carried from ID into EX.
package pipe_pkg;

    // ALU operation select driven by the decode control unit
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_MULT = 4'b1000,
        ALU_NOR  = 4'b1100,
        ALU_XOR  = 4'b1101,
        ALU_JMP  = 4'b1111
    } aluop_e;

    // Primary opcode field of the instruction word
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    // Control bundle; valid travels with the control bits so a bubble is one constant
    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       jtopc;
        logic       branch;
        logic       regwrite;
        logic [3:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the
// instruction currently in ID.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dest,
    output logic             load_use_c
);

    logic rs_match;
    logic rt_match;

    // Writes to r0 are discarded, so a load targeting r0 never creates a dependency
    always_comb begin
        rs_match   = (ex_dest == id_rs);
        rt_match   = id_uses_rt && (ex_dest == id_rt);
        load_use_c = id_valid && ex_valid && ex_memread
                     && (ex_dest != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush on taken
// branch/jump and freeze while EX is busy.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_memwrite,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic              id_jtopc,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic [3:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_up,
    output logic              bubble,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_memwrite,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_jtopc,
    output logic              ex_branch,
    output logic              ex_regwrite,
    output logic [3:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dest
);

    ctrl_t             ctrl_q,    ctrl_d;
    ctrl_t             id_ctrl_c;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_W-1:0]  rs_q,      rs_d;
    logic [REG_W-1:0]  rt_q,      rt_d;
    logic [REG_W-1:0]  dest_q,    dest_d;
    logic              load_use_c;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_valid   (ctrl_q.valid),
        .ex_memread (ctrl_q.memread),
        .ex_dest    (dest_q),
        .load_use_c (load_use_c)
    );

    // Upstream stall and bubble indication; a flush cancels both so the target is fetched
    always_comb begin
        stall_up = !flush && (ex_hold || load_use_c);
        bubble   = !flush && !ex_hold && load_use_c;
    end

    // Decoded control for capture; an empty ID slot carries no control at all
    always_comb begin
        id_ctrl_c = CTRL_NOP;
        if (id_valid) begin
            id_ctrl_c.valid    = 1'b1;
            id_ctrl_c.alusrc   = id_alusrc;
            id_ctrl_c.memwrite = id_memwrite;
            id_ctrl_c.memread  = id_memread;
            id_ctrl_c.memtoreg = id_memtoreg;
            id_ctrl_c.jtopc    = id_jtopc;
            id_ctrl_c.branch   = id_branch;
            id_ctrl_c.regwrite = id_regwrite;
            id_ctrl_c.aluop    = id_aluop;
        end
    end

    // Next register contents: flush > hold > load-use bubble > capture
    always_comb begin
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dest_d    = dest_q;
        if (flush) begin
            ctrl_d = CTRL_NOP;
        end else if (ex_hold) begin
            ctrl_d = ctrl_q;
        end else if (load_use_c) begin
            ctrl_d = CTRL_NOP;
        end else begin
            ctrl_d    = id_ctrl_c;
            pc_d      = id_pc;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            dest_d    = id_dest;
        end
    end

    // Pipeline register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_NOP;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
        end
    end

    assign ex_valid    = ctrl_q.valid;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_jtopc    = ctrl_q.jtopc;
    assign ex_branch   = ctrl_q.branch;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_pc       = pc_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dest     = dest_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    // Saturating event counts for bubbles and flushes
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    // Counter width has no hardware behind it in this build
    logic [CNT_W-1:0] cnt_w_unused;
    assign cnt_w_unused = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage. Define ID_EX_PERF_CNT_EN to
// also check the saturating counters (built with CNT_W=4).
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
`ifdef ID_EX_PERF_CNT_EN
    localparam int unsigned CNT_W  = 4;
`else
    localparam int unsigned CNT_W  = 16;
`endif

    typedef struct packed {
        logic              valid;
        logic              alusrc;
        logic              memwrite;
        logic              memread;
        logic              memtoreg;
        logic              jtopc;
        logic              branch;
        logic              regwrite;
        logic [3:0]        aluop;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dest;
    } stage_t;

    typedef struct {
        stage_t           st;
        logic [CNT_W-1:0] bcnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    stage_t id_s;
    logic id_uses_rt, flush, ex_hold;
    logic stall_up, bubble;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
    logic ex_valid, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_jtopc, ex_branch, ex_regwrite;
    logic [3:0] ex_aluop;
    logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_W-1:0] ex_rs, ex_rt, ex_dest;
    stage_t obs;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];
    stage_t model;
    logic [CNT_W-1:0] m_bcnt, m_fcnt;
    logic obs_stall, obs_bubble;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_s.valid),
        .id_alusrc   (id_s.alusrc),
        .id_memwrite (id_s.memwrite),
        .id_memread  (id_s.memread),
        .id_memtoreg (id_s.memtoreg),
        .id_jtopc    (id_s.jtopc),
        .id_branch   (id_s.branch),
        .id_regwrite (id_s.regwrite),
        .id_aluop    (id_s.aluop),
        .id_pc       (id_s.pc),
        .id_rs_data  (id_s.rs_data),
        .id_rt_data  (id_s.rt_data),
        .id_imm      (id_s.imm),
        .id_rs       (id_s.rs),
        .id_rt       (id_s.rt),
        .id_dest     (id_s.dest),
        .id_uses_rt  (id_uses_rt),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .stall_up    (stall_up),
        .bubble      (bubble),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .ex_valid    (ex_valid),
        .ex_alusrc   (ex_alusrc),
        .ex_memwrite (ex_memwrite),
        .ex_memread  (ex_memread),
        .ex_memtoreg (ex_memtoreg),
        .ex_jtopc    (ex_jtopc),
        .ex_branch   (ex_branch),
        .ex_regwrite (ex_regwrite),
        .ex_aluop    (ex_aluop),
        .ex_pc       (ex_pc),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_dest     (ex_dest)
    );

`ifndef ID_EX_PERF_CNT_EN
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    assign obs = {ex_valid, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_jtopc,
                  ex_branch, ex_regwrite, ex_aluop, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
                  ex_rs, ex_rt, ex_dest};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // An instruction in EX that loads into a nonzero register read by ID
    function automatic logic depends_on_load(input stage_t ex, input stage_t id, input logic uses_rt);
        if (!(ex.valid && ex.memread) || ex.dest == 0 || !id.valid) return 1'b0;
        return (ex.dest == id.rs) || (uses_rt && ex.dest == id.rt);
    endfunction

    // Empty slot: no instruction and no side effects; data fields left as-is
    function automatic stage_t emptied(input stage_t s);
        stage_t r = s;
        r.valid = 0; r.alusrc = 0; r.memwrite = 0; r.memread = 0;
        r.memtoreg = 0; r.jtopc = 0; r.branch = 0; r.regwrite = 0; r.aluop = 4'b0000;
        return r;
    endfunction

    function automatic stage_t rnd_stage();
        stage_t s;
        s.valid    = ($urandom_range(0, 3) != 0);
        s.alusrc   = 1'($urandom);
        s.memwrite = 1'($urandom);
        s.memread  = 1'($urandom);
        s.memtoreg = 1'($urandom);
        s.jtopc    = 1'($urandom);
        s.branch   = 1'($urandom);
        s.regwrite = 1'($urandom);
        s.aluop    = 4'($urandom);
        s.pc       = DATA_W'($urandom);
        s.rs_data  = DATA_W'($urandom);
        s.rt_data  = DATA_W'($urandom);
        s.imm      = DATA_W'($urandom);
        s.rs       = REG_W'($urandom_range(0, 3));
        s.rt       = REG_W'($urandom_range(0, 3));
        s.dest     = REG_W'($urandom_range(0, 3));
        return s;
    endfunction

    function automatic stage_t mk(input logic memread, input logic [3:0] aluop,
                                  input int rs, input int rt, input int dest);
        stage_t s = rnd_stage();
        s.valid = 1'b1; s.memread = memread; s.memtoreg = memread;
        s.memwrite = 1'b0; s.regwrite = 1'b1; s.aluop = aluop;
        s.rs = REG_W'(rs); s.rt = REG_W'(rt); s.dest = REG_W'(dest);
        return s;
    endfunction

    // Drive one cycle, check the combinational outputs, push the post-edge expectation
    task automatic apply(input stage_t id, input logic uses_rt, input logic fl,
                         input logic hd, input logic rst);
        logic lu, e_stall, e_bub;
        exp_t e;
        @(negedge clk);
        rst_n = ~rst; id_s = id; id_uses_rt = uses_rt; flush = fl; ex_hold = hd;
        #1;
        lu      = depends_on_load(model, id, uses_rt);
        e_stall = !fl && (hd || lu);
        e_bub   = !fl && !hd && lu;
        obs_stall  = stall_up;
        obs_bubble = bubble;
        check("stall_up", 64'(stall_up), 64'(e_stall));
        check("bubble", 64'(bubble), 64'(e_bub));
        if (rst) begin
            model = '0; m_bcnt = '0; m_fcnt = '0;
        end else begin
            if (fl || (!hd && lu)) model = emptied(model);
            else if (!hd)          model = id.valid ? id : emptied(id);
            if (e_bub && m_bcnt != '1) m_bcnt = m_bcnt + 1'b1;
            if (fl && m_fcnt != '1)    m_fcnt = m_fcnt + 1'b1;
        end
        e.st = model; e.bcnt = m_bcnt; e.fcnt = m_fcnt;
        sb_q.push_back(e);
    endtask

    // Monitor: after every edge compare the EX register against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("ex_valid", 64'(obs.valid), 64'(e.st.valid));
                check("ex_ctrl", 64'(obs[DATA_W*4+REG_W*3 +: 11]), 64'(e.st[DATA_W*4+REG_W*3 +: 11]));
                check("ex_aluop", 64'(obs.aluop), 64'(e.st.aluop));
                if (e.st.valid) begin
                    check("ex_pc", 64'(obs.pc), 64'(e.st.pc));
                    check("ex_rs_data", 64'(obs.rs_data), 64'(e.st.rs_data));
                    check("ex_rt_data", 64'(obs.rt_data), 64'(e.st.rt_data));
                    check("ex_imm", 64'(obs.imm), 64'(e.st.imm));
                    check("ex_regs", 64'({obs.rs, obs.rt, obs.dest}), 64'({e.st.rs, e.st.rt, e.st.dest}));
                end
`ifdef ID_EX_PERF_CNT_EN
                check("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
                check("flush_cnt", 64'(flush_cnt), 64'(e.fcnt));
`endif
            end
        end
    end

    initial begin
        stage_t s;
        int hold_unchanged;
        model = '0; m_bcnt = '0; m_fcnt = '0;
        rst_n = 1'b0; id_s = '0; id_uses_rt = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with random ID contents
        repeat (2) apply(rnd_stage(), 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("reset_ex_valid", 64'(ex_valid), 64'd0);
        check("reset_ex_aluop", 64'(ex_aluop), 64'd0);
        check("reset_stall", 64'(stall_up), 64'd0);

        // Normal flow: add -> EX one cycle later
        apply(mk(1'b0, 4'(ALU_ADD), 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("add_aluop", 64'(ex_aluop), 64'h2);
        check("add_dest", 64'(ex_dest), 64'd3);
        check("add_valid", 64'(ex_valid & ex_regwrite), 64'd1);

        // Load-use on rs: exactly one stall cycle
        apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 5), 1'b0, 1'b0, 1'b0, 1'b0);
        s = mk(1'b0, 4'(ALU_ADD), 5, 1, 6);
        apply(s, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_bubble", 64'({obs_stall, obs_bubble}), 64'b11);
        apply(s, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_release", 64'({obs_stall, obs_bubble}), 64'b00);

        // rt dependency only counts when the instruction reads rt
        apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 7), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(mk(1'b0, 4'(ALU_ADD), 1, 7, 7), 1'b0, 1'b0, 1'b0, 1'b0);
        check("addi_rt_nostall", 64'(obs_stall), 64'd0);
        apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 7), 1'b0, 1'b0, 1'b0, 1'b0);
        s = mk(1'b0, 4'(ALU_ADD), 1, 7, 0);
        apply(s, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sw_rt_stall", 64'(obs_stall), 64'd1);
        apply(s, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sw_rt_release", 64'(obs_stall), 64'd0);

        // Load into r0 never stalls
        apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(mk(1'b0, 4'(ALU_ADD), 0, 0, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        check("r0_nostall", 64'(obs_stall), 64'd0);

        // Flush beats hold and a pending load-use
        apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 5), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(mk(1'b0, 4'(ALU_SUB), 5, 5, 4), 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_stall_bub", 64'({obs_stall, obs_bubble}), 64'b00);
        @(posedge clk); #2;
        check("flush_kill", 64'(ex_valid), 64'd0);

        // Hold alone for three cycles freezes EX and stalls upstream
        apply(mk(1'b0, 4'(ALU_XOR), 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        hold_unchanged = 0;
        for (int i = 0; i < 3; i++) begin
            apply(rnd_stage(), 1'b1, 1'b0, 1'b1, 1'b0);
            if (obs_stall === 1'b1) hold_unchanged++;
        end
        check("hold_stall_cycles", 64'(hold_unchanged), 64'd3);
        @(posedge clk); #2;
        check("hold_aluop", 64'(ex_aluop), 64'hD);

        // Random traffic with hazards, flushes, holds and occasional resets
        for (int i = 0; i < 2000; i++) begin
            apply(rnd_stage(), 1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 63) == 0));
        end

`ifdef ID_EX_PERF_CNT_EN
        // Back-to-back load/dependent pairs drive the bubble count to saturation
        for (int i = 0; i < 20; i++) begin
            apply(mk(1'b1, 4'(ALU_ADD), 0, 0, 2), 1'b0, 1'b0, 1'b0, 1'b0);
            s = mk(1'b0, 4'(ALU_ADD), 2, 1, 3);
            apply(s, 1'b0, 1'b0, 1'b0, 1'b0);
            apply(s, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #2;
        check("bubble_cnt_sat", 64'(bubble_cnt), 64'd15);
        apply(rnd_stage(), 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("bubble_cnt_rst", 64'(bubble_cnt), 64'd0);
`endif

        apply(rnd_stage(), 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
